// File: rtl/alu_sched_pkg.sv
// Shared constants, FSM state encoding and opcode helpers for the ALU request scheduler.
// The optional WAIT watchdog (ALU_TIMEOUT_EN) takes its default limit from here.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // One-hot to match the encoding style of the ALU's own control unit.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD_X = 5'b00010,
    S_LOAD_Y = 5'b00100,
    S_WAIT   = 5'b01000,
    S_RESP   = 5'b10000
  } state_e;

  function automatic logic has_hi_byte(input logic [1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB: r = 1'b0;
      OP_MUL, OP_DIV: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_request_scheduler_if.sv
// Requester-side bus of the ALU request scheduler: per-requester request vectors
// and the single shared response channel.
interface alu_request_scheduler_if #(
  parameter int N_REQ = 2
) ();

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_op;
  logic [8*N_REQ-1:0] req_x;
  logic [8*N_REQ-1:0] req_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_request_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request scanning upward
// from ptr with wrap-around, returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]                          req,
  input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] ptr,
  output logic [N_REQ-1:0]                          gnt,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] gnt_idx,
  output logic                                      gnt_vld
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0] k;
  logic            hit;

  // Priority scan starting at ptr; the first hit wins and masks later slots.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k       = ID_W'((int'(ptr) + i) % N_REQ);
      hit     = ~gnt_vld & req[k];
      gnt[k]  = gnt[k] | hit;
      gnt_idx = hit ? k : gnt_idx;
      gnt_vld = gnt_vld | hit;
    end
  end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one sequential ALU among N_REQ requesters: round-robin grant, BEGIN/X/Y
// load sequence, result capture on END, valid/ready response. ALU_TIMEOUT_EN adds a WAIT watchdog.
module alu_request_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ = 2
`ifdef ALU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  alu_request_scheduler_if.slave       bus,
  output logic                         alu_begin,
  output logic [1:0]                   alu_op_code,
  output logic [7:0]                   alu_inbus,
  input  logic [7:0]                   alu_outbus,
  input  logic                         alu_end,
  output logic                         alu_reset
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      y_q, y_d;
  logic [7:0]      prev_q, prev_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            alu_begin_q, alu_begin_d;
  logic [1:0]      alu_op_code_q, alu_op_code_d;
  logic [7:0]      alu_inbus_q, alu_inbus_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_vld;
  logic [N_REQ-1:0] req_ready_s;

`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             abort_q, abort_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign prev_d = alu_outbus;

  // Next-state and output decode for the job sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    op_d          = op_q;
    y_d           = y_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    alu_begin_d   = 1'b0;
    alu_op_code_d = alu_op_code_q;
    alu_inbus_d   = 8'h00;
    req_ready_s   = '0;
`ifdef ALU_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    abort_d       = 1'b0;
    rsp_err_d     = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Acceptance is combinational so req_ready lands in the grant cycle.
        if (arb_vld && !reset) begin
          req_ready_s   = arb_gnt;
          grant_d       = arb_idx;
          op_d          = bus.req_op[2*arb_idx +: 2];
          y_d           = bus.req_y[8*arb_idx +: 8];
          alu_begin_d   = 1'b1;
          alu_op_code_d = bus.req_op[2*arb_idx +: 2];
          alu_inbus_d   = bus.req_x[8*arb_idx +: 8];
          state_d       = S_LOAD_X;
        end else begin
          state_d       = S_IDLE;
        end
      end
      S_LOAD_X: begin
        alu_inbus_d = y_q;
        state_d     = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        state_d = S_WAIT;
`ifdef ALU_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (alu_end) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_data_d  = {has_hi_byte(op_q) ? prev_q : 8'h00, alu_outbus};
          state_d     = S_RESP;
`ifdef ALU_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          abort_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_data_d  = 16'h0000;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
          state_d     = S_WAIT;
        end
`else
        end else begin
          state_d     = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        // The pointer only moves on completion, which bounds every requester's wait.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      op_q          <= 2'b00;
      y_q           <= 8'h00;
      prev_q        <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= 16'h0000;
      alu_begin_q   <= 1'b0;
      alu_op_code_q <= 2'b00;
      alu_inbus_q   <= 8'h00;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      abort_q       <= 1'b0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      op_q          <= op_d;
      y_q           <= y_d;
      prev_q        <= prev_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      alu_begin_q   <= alu_begin_d;
      alu_op_code_q <= alu_op_code_d;
      alu_inbus_q   <= alu_inbus_d;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      abort_q       <= abort_d;
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign alu_begin     = alu_begin_q;
  assign alu_op_code   = alu_op_code_q;
  assign alu_inbus     = alu_inbus_q;

`ifdef ALU_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
  assign alu_reset     = reset | abort_q;
`else
  assign bus.rsp_err   = 1'b0;
  assign alu_reset     = reset;
`endif

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Self-checking bench for alu_request_scheduler: behavioural ALU, vector table,
// scoreboard of expected responses, and hand sequences for arbitration/backpressure/reset.
module tb_alu_request_scheduler;
  import alu_sched_pkg::*;

  localparam int N_REQ = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_request_scheduler_if #(.N_REQ(N_REQ)) bus ();

  logic       alu_begin;
  logic [1:0] alu_op_code;
  logic [7:0] alu_inbus;
  logic [7:0] alu_outbus = 8'h00;
  logic       alu_end    = 1'b0;
  logic       alu_reset;

  alu_request_scheduler #(.N_REQ(N_REQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .alu_begin   (alu_begin),
    .alu_op_code (alu_op_code),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_end     (alu_end),
    .alu_reset   (alu_reset)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    int          lat;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  // Behavioural ALU: X on BEGIN cycle, Y next, END lat cycles after Y.
  int          model_lat  = 3;
  bit          model_hang = 1'b0;
  int          m_phase    = 0;
  int          m_cnt      = 0;
  logic [1:0]  m_op;
  logic [7:0]  m_x, m_y;
  logic [15:0] m_res;

  function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'b00:   return {8'h00, 8'(x + y)};
      2'b01:   return {8'h00, 8'(x - y)};
      2'b10:   return 16'(x) * 16'(y);
      2'b11:   return (y == 8'h00) ? {x, 8'hFF} : {8'(x % y), 8'(x / y)};
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (alu_reset) begin
      m_phase    = 0;
      alu_end    = 1'b0;
      alu_outbus = 8'h00;
    end else begin
      case (m_phase)
        0: begin
          alu_end    = 1'b0;
          alu_outbus = 8'h00;
          if (alu_begin) begin
            m_x     = alu_inbus;
            m_op    = alu_op_code;
            m_phase = 1;
          end
        end
        1: begin
          m_y     = alu_inbus;
          m_res   = alu_ref(m_op, m_x, m_y);
          m_cnt   = model_lat;
          m_phase = 2;
        end
        2: begin
          if (!model_hang) begin
            m_cnt--;
            if (m_cnt == 0) begin
              alu_outbus = m_res[7:0];
              alu_end    = 1'b1;
              m_phase    = 0;
            end else if (m_cnt == 1 && m_op[1]) begin
              alu_outbus = m_res[15:8];
            end else begin
              alu_outbus = 8'hA5;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Response monitor: compares each completed handshake against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), e.id);
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    bus.req_op[2*id +: 2] = op;
    bus.req_x[8*id +: 8]  = x;
    bus.req_y[8*id +: 8]  = y;
  endtask

  task automatic push_exp(input int id, input logic [15:0] data, input logic err);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int id, input string name);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check(name, 32'(bus.req_ready), 32'd1 << id);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 200) begin
      tick();
      #1;
      n++;
    end
    check(name, sb.size(), 32'd0);
  endtask

  task automatic check_reset_outs();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_alu_out",   32'({alu_begin, alu_op_code, alu_inbus}), 32'd0);
    check("rst_alu_reset", 32'(alu_reset), 32'd1);
  endtask

  task automatic run_job(input vec_t v);
    tick();
    set_req(v.id, v.op, v.x, v.y);
    model_lat     = v.lat;
    bus.req_valid = N_REQ'(1) << v.id;
    push_exp(v.id, v.exp, 1'b0);
    wait_grant(v.id, "vec_grant");
    tick();
    bus.req_valid = '0;
    #1;
    check("vec_load_x", 32'({alu_begin, alu_op_code, alu_inbus}), 32'({1'b1, v.op, v.x}));
    tick();
    #1;
    check("vec_load_y", 32'({alu_begin, alu_op_code, alu_inbus}), 32'({1'b0, v.op, v.y}));
    drain("vec_drain");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [N_REQ-1:0] prev_gnt;

    vecs[0] = '{0, 2'b00, 8'h12, 8'h34, 3, 16'h0046};
    vecs[1] = '{1, 2'b10, 8'h0C, 8'h0B, 4, 16'h0084};
    vecs[2] = '{0, 2'b01, 8'h10, 8'h20, 2, 16'h00F0};
    vecs[3] = '{1, 2'b11, 8'h64, 8'h07, 5, 16'h020E};
    vecs[4] = '{0, 2'b10, 8'hFF, 8'hFF, 2, 16'hFE01};
    vecs[5] = '{1, 2'b00, 8'hFF, 8'h01, 1, 16'h0000};
    vecs[6] = '{0, 2'b11, 8'h10, 8'h00, 3, 16'h10FF};
    vecs[7] = '{1, 2'b01, 8'h00, 8'h01, 6, 16'h00FF};

    bus.req_valid = 2'b11;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) tick();
    #1;
    check_reset_outs();
    tick();
    bus.req_valid = '0;
    reset         = 1'b0;

    // Contention: both requesters held valid, grants must alternate from 0.
    tick();
    set_req(0, 2'b00, 8'h01, 8'h02);
    set_req(1, 2'b10, 8'h03, 8'h04);
    model_lat = 2;
    for (int g = 0; g < 4; g++) push_exp(g % 2, (g % 2 == 0) ? 16'h0003 : 16'h000C, 1'b0);
    bus.req_valid = 2'b11;
    prev_gnt = '0;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) tick();
      wait_grant(g % 2, "rr_order");
      check("rr_no_repeat", 32'(bus.req_ready != prev_gnt), 32'd1);
      prev_gnt = bus.req_ready;
    end
    tick();
    bus.req_valid = '0;
    drain("rr_drain");

    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // Backpressure: response held while rsp_ready is low, no new acceptance.
    tick();
    bus.rsp_ready = 1'b0;
    set_req(0, 2'b00, 8'h05, 8'h06);
    model_lat = 2;
    push_exp(0, 16'h000B, 1'b0);
    bus.req_valid = 2'b01;
    wait_grant(0, "bp_grant");
    tick();
    set_req(1, 2'b10, 8'h02, 8'h03);
    bus.req_valid = 2'b10;
    n = 0;
    #1;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_data",  32'(bus.rsp_data), 32'h000B);
      check("bp_rsp_id",    32'(bus.rsp_id), 32'd0);
      check("bp_no_ready",  32'(bus.req_ready), 32'd0);
      tick();
      #1;
    end
    tick();
    push_exp(1, 16'h0006, 1'b0);
    bus.rsp_ready = 1'b1;
    wait_grant(1, "bp_next_grant");
    tick();
    bus.req_valid = '0;
    drain("bp_drain");

    // Reset while a job is stuck in WAIT; afterwards arbitration restarts at 0.
    run_job('{0, 2'b00, 8'h21, 8'h22, 2, 16'h0043});
    tick();
    model_hang = 1'b1;
    set_req(1, 2'b11, 8'h40, 8'h08);
    bus.req_valid = 2'b10;
    wait_grant(1, "hang_grant");
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    #1;
    check_reset_outs();
    reset      = 1'b0;
    model_hang = 1'b0;
    tick();
    #1;
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_rst_alu_reset", 32'(alu_reset), 32'd0);
    tick();
    set_req(0, 2'b10, 8'h10, 8'h10);
    set_req(1, 2'b00, 8'h01, 8'h01);
    model_lat = 2;
    push_exp(0, 16'h0100, 1'b0);
    bus.req_valid = 2'b11;
    wait_grant(0, "post_rst_rr");
    tick();
    bus.req_valid = '0;
    drain("post_rst_drain");

`ifdef ALU_TIMEOUT_EN
    // Watchdog: END never arrives, abort after 64 WAIT cycles.
    tick();
    model_hang = 1'b1;
    set_req(0, 2'b11, 8'h50, 8'h05);
    push_exp(0, 16'h0000, 1'b1);
    bus.req_valid = 2'b01;
    wait_grant(0, "tmo_grant");
    tick();
    bus.req_valid = '0;
    tick();
    n = 0;
    tick();
    #1;
    while (!bus.rsp_valid && n < 200) begin
      n++;
      tick();
      #1;
    end
    check("tmo_wait_cycles", n, 32'd64);
    check("tmo_alu_reset", 32'(alu_reset), 32'd1);
    check("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
    model_hang = 1'b0;
    tick();
    #1;
    check("tmo_alu_reset_pulse", 32'(alu_reset), 32'd0);
    drain("tmo_drain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
